spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter that shares one `spi_master` instance between `REQ_COUNT` independent requesters. It sits directly in front of the master: it latches the winning requester's transfer descriptor, issues `start_trans`, and tracks `busy` through the whole transaction. It then returns the received word and a one-cycle acknowledge to that requester. Only one SPI transaction is ever in flight.

## Interface
Parameters:
- `REQ_COUNT`, 4: number of requesters (2..8).
- `SLAVE_ADDRS_LEN`, 3: chip-address width, matches the master.

Ports:
- `clk` in 1: system clock; same clock as the SPI master.
- `rst` in 1: asynchronous, active-high reset.
- `req` in REQ_COUNT: per-requester transfer request, level.
- `req_tx_data` in 32*REQ_COUNT: requester i word at [32i+31:32i].
- `req_chip_addr` in SLAVE_ADDRS_LEN*REQ_COUNT: requester i chip address at [i*SLAVE_ADDRS_LEN +: SLAVE_ADDRS_LEN].
- `req_length` in 2*REQ_COUNT: requester i length code at [2i+1:2i] (00=8b, 01=16b, 10=24b, 11=32b).
- `ack` out REQ_COUNT: one-hot, one-cycle pulse to the served requester.
- `rx_data` out 32: received word, valid while `ack` is high and held until the next `ack`.
- `grant` out REQ_COUNT: one-hot owner of the current transaction; 0 when idle.
- `arb_busy` out 1: high in every state except IDLE.
- `spi_start` out 1: to master `start_trans`.
- `spi_busy` in 1: from master `busy`.
- `spi_tx_data` out 32, `spi_chip_addr` out SLAVE_ADDRS_LEN, `spi_length` out 2: to the master; registered.
- `spi_rx_data` in 32: from master `rx_data`.

## Operation
States: IDLE, START, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - If any `req` bit is high, select the winner by round-robin.
  - Search starts at `last+1` mod REQ_COUNT and wraps.
  - `last` resets to REQ_COUNT-1, so requester 0 has first priority after reset.
  - Latch the winner's tx_data, chip_addr and length into the `spi_*` registers.
  - Set `grant`, then go to START.
  - If no request is pending, stay in IDLE.
- START: drive `spi_start`=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY:
  - When `spi_busy`=1, go to WAIT_DONE.
  - Watchdog: if `spi_busy` has not risen 8 cycles after entry, go to DONE with `rx_data`=32'h0. The `ack` still pulses.
- WAIT_DONE: when `spi_busy`=0, go to DONE. There is no timeout here, because SPI length depends on `division_ratio`.
- DONE:
  - Capture `spi_rx_data` into `rx_data`.
  - Pulse `ack[winner]` for one cycle.
  - Set `last`=winner, clear `grant`, return to IDLE.
- Descriptor latching:
  - The `spi_*` descriptor registers hold their value from IDLE exit until the next grant.
  - Requester inputs may change freely after the grant cycle.
- Handshake:
  - A requester holds `req` high until it sees `ack`, and must drop `req` on the cycle after `ack`.
  - If `req` is still high in IDLE after DONE, it is treated as a new request at the lowest priority.
- Dropped requests: deasserting `req` before the grant simply withdraws the request. Deasserting it after the grant has no effect; the transaction completes and `ack` still pulses.
- Simultaneous requests are resolved only by the round-robin order. No requester is served twice while another requester is continuously pending.
- Reset, at any time:
  - State goes to IDLE and `last` to REQ_COUNT-1.
  - All outputs go to 0: `ack`, `rx_data`, `grant`, `arb_busy`, `spi_start`, `spi_tx_data`, `spi_chip_addr`, `spi_length`.
  - A transfer already started in the master is abandoned; its `spi_busy` fall is ignored.

## Timing
- All outputs are registered.
- The grant is visible 1 cycle after `req` is sampled in IDLE; `spi_start` follows 1 cycle after the grant.
- `ack` pulses 2 cycles after `spi_busy` falls: one cycle for WAIT_DONE to see it, one cycle for DONE.
- Minimum gap between consecutive `spi_start` pulses is transaction time + 4 cycles.
- `spi_rx_data` is stable from the `spi_busy` fall onward and is sampled in DONE.

## Test plan
- Single request:
  - Stimulus: `req`=0001, requester 0 tx=32'hA5, len=00, addr=2; model master echoes rx=32'h3C.
  - Required: `spi_start` pulses once; `spi_tx_data`=0xA5, `spi_chip_addr`=2; `ack`=0001 with `rx_data`=32'h3C.
- All four requesting, held continuously:
  - Required: `ack` order is 0,1,2,3,0; each descriptor reaches the master unaltered.
- Fairness:
  - Stimulus: requester 2 served, then `req`=0101.
  - Required: requester 0 is granted next, because the search wraps after 2.
- Watchdog:
  - Stimulus: model never raises `spi_busy`.
  - Required: `ack` 10 cycles after `spi_start`, `rx_data`=0, state back to IDLE.
- Reset mid-transfer:
  - Stimulus: assert `rst` during WAIT_DONE.
  - Required: immediately all outputs are 0 and `grant`=0; the first post-reset request from requester 0 is served normally.
- Withdrawn request:
  - Stimulus: requester 1 raises `req` and drops it before arbitration while the arbiter is in WAIT_DONE.
  - Required: no grant or `ack` is ever issued to requester 1.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter that shares one SPI master between REQ_COUNT requesters.
// It latches the winner's descriptor, issues start_trans, and follows the master's
// busy through the transaction. It then returns the received word with a
// one-cycle ack. Only one transaction is in flight at any time.
module spi_arbiter #(
  parameter int unsigned REQ_COUNT       = 4,
  parameter int unsigned SLAVE_ADDRS_LEN = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_COUNT-1:0]                 req,
  input  logic [32*REQ_COUNT-1:0]              req_tx_data,
  input  logic [SLAVE_ADDRS_LEN*REQ_COUNT-1:0] req_chip_addr,
  input  logic [2*REQ_COUNT-1:0]               req_length,
  output logic [REQ_COUNT-1:0]                 ack,
  output logic [31:0]                          rx_data,
  output logic [REQ_COUNT-1:0]                 grant,
  output logic                                 arb_busy,
  output logic                                 spi_start,
  input  logic                                 spi_busy,
  output logic [31:0]                          spi_tx_data,
  output logic [SLAVE_ADDRS_LEN-1:0]           spi_chip_addr,
  output logic [1:0]                           spi_length,
  input  logic [31:0]                          spi_rx_data
);

  localparam int unsigned IW       = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
  localparam logic [3:0]  WD_LIMIT = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_t;

  state_t                       state, state_nxt;
  logic [IW-1:0]                last;
  logic [IW-1:0]                cur;
  logic [IW-1:0]                pick;
  logic [IW-1:0]                cand;
  logic                         found;
  logic [3:0]                   wd_cnt;
  logic                         timed_out;
  logic [31:0]                  pick_tx;
  logic [SLAVE_ADDRS_LEN-1:0]   pick_addr;
  logic [1:0]                   pick_len;

  // Round-robin search starting one past the last served requester, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int unsigned k = 1; k <= REQ_COUNT; k++) begin
      cand = IW'((32'(last) + k) % REQ_COUNT);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Select the descriptor fields of the chosen requester
  always_comb begin
    pick_tx   = '0;
    pick_addr = '0;
    pick_len  = '0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (pick == IW'(i)) begin
        pick_tx   = req_tx_data[i*32 +: 32];
        pick_addr = req_chip_addr[i*SLAVE_ADDRS_LEN +: SLAVE_ADDRS_LEN];
        pick_len  = req_length[i*2 +: 2];
      end
    end
  end

  // Next-state logic for the transaction sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (found) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (spi_busy)                state_nxt = WAIT_DONE;
        else if (wd_cnt == WD_LIMIT) state_nxt = DONE;
      end
      WAIT_DONE: if (!spi_busy) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered outputs, descriptor latch, watchdog and round-robin pointer.
  // Each output register reflects the action of the state being left, so
  // spi_start lands one cycle after grant and ack one cycle after DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last          <= IW'(REQ_COUNT - 1);
      cur           <= '0;
      wd_cnt        <= '0;
      timed_out     <= 1'b0;
      ack           <= '0;
      rx_data       <= '0;
      grant         <= '0;
      arb_busy      <= 1'b0;
      spi_start     <= 1'b0;
      spi_tx_data   <= '0;
      spi_chip_addr <= '0;
      spi_length    <= '0;
    end else begin
      spi_start <= 1'b0;
      ack       <= '0;
      arb_busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          timed_out <= 1'b0;
          if (found) begin
            cur           <= pick;
            grant         <= REQ_COUNT'(1) << pick;
            spi_tx_data   <= pick_tx;
            spi_chip_addr <= pick_addr;
            spi_length    <= pick_len;
          end
        end
        START: begin
          spi_start <= 1'b1;
          wd_cnt    <= '0;
        end
        WAIT_BUSY: begin
          if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + 4'd1;
          if (!spi_busy && wd_cnt == WD_LIMIT) timed_out <= 1'b1;
        end
        DONE: begin
          rx_data <= timed_out ? '0 : spi_rx_data;
          ack     <= REQ_COUNT'(1) << cur;
          grant   <= '0;
          last    <= cur;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with a small behavioural SPI master.
module tb_spi_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [127:0] req_tx_data = '0;
  logic [11:0]  req_chip_addr = '0;
  logic [7:0]   req_length = '0;
  logic [3:0]   ack;
  logic [31:0]  rx_data;
  logic [3:0]   grant;
  logic         arb_busy;
  logic         spi_start;
  logic         spi_busy;
  logic [31:0]  spi_tx_data;
  logic [2:0]   spi_chip_addr;
  logic [1:0]   spi_length;
  logic [31:0]  spi_rx_data;

  int checks = 0;
  int errors = 0;

  // Behavioural master state
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic        m_dead = 1'b0;
  logic [31:0] m_tx = '0;
  logic [2:0]  m_addr = '0;
  logic [1:0]  m_len = '0;
  int          n_starts = 0;

  spi_arbiter #(.REQ_COUNT(4), .SLAVE_ADDRS_LEN(3)) dut (
    .clk(clk), .rst(rst), .req(req), .req_tx_data(req_tx_data),
    .req_chip_addr(req_chip_addr), .req_length(req_length), .ack(ack),
    .rx_data(rx_data), .grant(grant), .arb_busy(arb_busy), .spi_start(spi_start),
    .spi_busy(spi_busy), .spi_tx_data(spi_tx_data), .spi_chip_addr(spi_chip_addr),
    .spi_length(spi_length), .spi_rx_data(spi_rx_data)
  );

  always #5 clk = ~clk;

  assign spi_busy    = m_busy;
  assign spi_rx_data = m_tx ^ 32'h0000_0099;

  // Master model: busy for 3+2*len cycles after a start; ignores starts while busy or dead
  always @(posedge clk) begin
    if (spi_start) n_starts <= n_starts + 1;
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_busy <= 1'b0;
    end else if (spi_start && !m_dead) begin
      m_busy <= 1'b1;
      m_cnt  <= 3 + 2 * int'(spi_length);
      m_tx   <= spi_tx_data;
      m_addr <= spi_chip_addr;
      m_len  <= spi_length;
    end
  end

  task automatic set_req(input int i, input logic [31:0] tx, input logic [2:0] a, input logic [1:0] l);
    req_tx_data[i*32 +: 32] = tx;
    req_chip_addr[i*3 +: 3] = a;
    req_length[i*2 +: 2]    = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ack, grant, arb_busy, spi_start} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: ack=%b grant=%b arb_busy=%b spi_start=%b, want all 0", ack, grant, arb_busy, spi_start);
    end
    checks++;
    if ({rx_data, spi_tx_data, spi_chip_addr, spi_length} !== '0) begin
      errors++;
      $display("FAIL reset_data: rx=%h tx=%h addr=%h len=%h, want 0", rx_data, spi_tx_data, spi_chip_addr, spi_length);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    int s0;
    set_req(0, 32'h0000_00A5, 3'd2, 2'b00);
    @(negedge clk);
    s0  = n_starts;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || spi_start !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b spi_start=%b, want 0001 0", grant, spi_start);
    end
    checks++;
    if (spi_tx_data !== 32'hA5 || spi_chip_addr !== 3'd2 || spi_length !== 2'b00) begin
      errors++;
      $display("FAIL single_desc: tx=%h addr=%0d len=%b, want a5 2 00", spi_tx_data, spi_chip_addr, spi_length);
    end
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start: spi_start=%b, want 1", spi_start);
    end
    wait_ack(40, ok);
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0001 || rx_data !== 32'h3C) begin
      errors++;
      $display("FAIL single_ack: seen=%0d ack=%b rx=%h, want 0001 3c", ok, ack, rx_data);
    end
    checks++;
    if (n_starts - s0 != 1) begin
      errors++;
      $display("FAIL single_starts: got %0d start pulses, want 1", n_starts - s0);
    end
    @(negedge clk);
    checks++;
    if (ack !== '0 || grant !== '0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: ack=%b grant=%b arb_busy=%b, want 0", ack, grant, arb_busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [31:0] txv[4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, txv[i], 3'(2*i+1), 2'(i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int e;
      e = order[n];
      wait_ack(60, ok);
      if (n == 4) req = '0;
      checks++;
      if (!ok || ack !== 4'(1 << e) || rx_data !== (txv[e] ^ 32'h99)) begin
        errors++;
        $display("FAIL rr_ack%0d: seen=%0d ack=%b rx=%h, want %b %h", n, ok, ack, rx_data, 4'(1 << e), txv[e] ^ 32'h99);
      end
      checks++;
      if (m_tx !== txv[e] || m_addr !== 3'(2*e+1) || m_len !== 2'(e)) begin
        errors++;
        $display("FAIL rr_desc%0d: tx=%h addr=%0d len=%0d, want %h %0d %0d", n, m_tx, m_addr, m_len, txv[e], 2*e+1, e);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    set_req(0, 32'hCAFE_0000, 3'd0, 2'b00);
    set_req(2, 32'hCAFE_0002, 3'd4, 2'b00);
    req = 4'b0100;
    wait_ack(40, ok);
    req = 4'b0101;
    checks++;
    if (!ok || ack !== 4'b0100) begin
      errors++;
      $display("FAIL fair_first: seen=%0d ack=%b, want 0100", ok, ack);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL fair_wrap: grant=%b, want 0001", grant);
    end
    wait_ack(40, ok);
    req = 4'b0100;
    checks++;
    if (!ok || ack !== 4'b0001 || rx_data !== (32'hCAFE_0000 ^ 32'h99)) begin
      errors++;
      $display("FAIL fair_second: seen=%0d ack=%b rx=%h, want 0001 %h", ok, ack, rx_data, 32'hCAFE_0000 ^ 32'h99);
    end
    wait_ack(40, ok);
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0100) begin
      errors++;
      $display("FAIL fair_third: seen=%0d ack=%b, want 0100", ok, ack);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int n;
    m_dead = 1'b1;
    set_req(1, 32'hDEAD_BEEF, 3'd6, 2'b11);
    req = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wd_start: no spi_start within 10 cycles, want a pulse");
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (ack != '0) break;
    end
    req = '0;
    checks++;
    if (ack !== 4'b0010 || n != 10 || rx_data !== 32'h0) begin
      errors++;
      $display("FAIL wd_ack: ack=%b after %0d cycles rx=%h, want 0010 after 10 rx 0", ack, n, rx_data);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL wd_idle: arb_busy=%b grant=%b, want 0 0000", arb_busy, grant);
    end
    m_dead = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stray;
    set_req(0, 32'h0BAD_0000, 3'd1, 2'b11);
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    #1;
    checks++;
    if (!ok || {ack, grant, arb_busy, spi_start, rx_data, spi_tx_data, spi_chip_addr, spi_length} !== '0) begin
      errors++;
      $display("FAIL rstmid_out: busy_seen=%0d ack=%b grant=%b arb_busy=%b tx=%h rx=%h, want all 0", ok, ack, grant, arb_busy, spi_tx_data, rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 30 && spi_busy; i++) begin
      @(negedge clk);
      if (ack != '0 || grant != '0) stray = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack != '0 || grant != '0) stray = 1'b1;
    end
    checks++;
    if (stray || spi_busy) begin
      errors++;
      $display("FAIL rstmid_ignore: stray=%0d spi_busy=%b, want 0 0", stray, spi_busy);
    end
    set_req(0, 32'h1234_5678, 3'd3, 2'b01);
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_grant: grant=%b, want 0001", grant);
    end
    wait_ack(40, ok);
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0001 || rx_data !== (32'h1234_5678 ^ 32'h99)) begin
      errors++;
      $display("FAIL rstmid_serve: seen=%0d ack=%b rx=%h, want 0001 %h", ok, ack, rx_data, 32'h1234_5678 ^ 32'h99);
    end
  endtask

  task automatic test_withdrawn();
    bit ok;
    bit seen1;
    set_req(0, 32'h7777_0000, 3'd2, 2'b11);
    set_req(1, 32'h7777_0001, 3'd5, 2'b00);
    req = 4'b0001;
    seen1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    req[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (grant[1] || ack[1]) seen1 = 1'b1;
    end
    req[1] = 1'b0;
    wait_ack(40, ok);
    req = '0;
    checks++;
    if (!ok || ack !== 4'b0001) begin
      errors++;
      $display("FAIL wd_r0_ack: seen=%0d ack=%b, want 0001", ok, ack);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant[1] || ack[1]) seen1 = 1'b1;
    end
    checks++;
    if (seen1 || grant !== '0) begin
      errors++;
      $display("FAIL withdrawn: req1 served=%0d grant=%b, want 0 0000", seen1, grant);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_watchdog();
    test_reset_mid();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
